// File: rtl/apu_clk_reset_gen.sv
// apu_clk_reset_gen
//   Runs on the 24.750 MHz APU PLL output clock. Synchronises and qualifies the
//   PLL lock, sequences the APU-domain reset, and derives the 24.576 MHz APU
//   master clock enable (fractional accumulator) and the 32 kHz DSP sample enable.
//   Optional feature macro: APU_LOCK_LOSS_CNT_EN adds the lock_loss_cnt port and a
//   saturating count of RUN->IDLE transitions.
module apu_clk_reset_gen #(
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned LOCK_HOLD   = 1024,
   parameter int unsigned CE_NUM      = 4096,
   parameter int unsigned CE_DEN      = 4125,
   parameter int unsigned SAMPLE_DIV  = 768
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       pll_locked,
   output logic       apu_rst_n,
   output logic       apu_ce,
   output logic       sample_ce,
   output logic       lock_ok
`ifdef APU_LOCK_LOSS_CNT_EN
   ,
   output logic [7:0] lock_loss_cnt
`endif
);

   localparam int unsigned HW = $clog2(LOCK_HOLD + 1);
   localparam int unsigned AW = $clog2(CE_NUM + CE_DEN);
   localparam int unsigned SW = $clog2(SAMPLE_DIV + 1);

   localparam logic [HW-1:0] HOLD_MAX = HW'(LOCK_HOLD);
   localparam logic [AW-1:0] NUM_W    = AW'(CE_NUM);
   localparam logic [AW-1:0] DEN_W    = AW'(CE_DEN);
   localparam logic [SW-1:0] SAMP_MAX = SW'(SAMPLE_DIV - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      COUNT = 2'd1,
      RUN   = 2'd2
   } state_t;

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   lock_s;
   state_t                 state, state_nxt;
   logic [HW-1:0]          hold_cnt, hold_cnt_nxt;
   logic [AW-1:0]          acc;
   logic [AW-1:0]          acc_sum;
   logic [SW-1:0]          samp_cnt;
   logic                   in_run;

   assign lock_s  = sync_q[SYNC_STAGES-1];
   assign in_run  = (state == RUN);
   assign acc_sum = acc + NUM_W;

   // Lock synchroniser: pll_locked is only ever seen through this chain.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], pll_locked};
      end
   end

   // Lock-qualification FSM state and hold counter registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         hold_cnt <= '0;
      end else begin
         state    <= state_nxt;
         hold_cnt <= hold_cnt_nxt;
      end
   end

   // Next state: any synced-lock drop restarts qualification from IDLE.
   always_comb begin
      state_nxt    = state;
      hold_cnt_nxt = hold_cnt;
      case (state)
         IDLE: begin
            hold_cnt_nxt = '0;
            if (lock_s) begin
               state_nxt    = COUNT;
               hold_cnt_nxt = HW'(1);
            end
         end
         COUNT: begin
            if (!lock_s) begin
               state_nxt    = IDLE;
               hold_cnt_nxt = '0;
            end else if (hold_cnt == HOLD_MAX) begin
               state_nxt = RUN;
            end else begin
               hold_cnt_nxt = hold_cnt + HW'(1);
            end
         end
         RUN: begin
            if (!lock_s) begin
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt    = IDLE;
            hold_cnt_nxt = '0;
         end
      endcase
   end

   // Registered reset/status outputs, one cycle behind the RUN state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         apu_rst_n <= 1'b0;
         lock_ok   <= 1'b0;
      end else begin
         apu_rst_n <= in_run;
         lock_ok   <= in_run;
      end
   end

   // Fractional accumulator and sample divider; both phases restart outside RUN,
   // so the enables drop on the same edge as apu_rst_n.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc       <= '0;
         samp_cnt  <= '0;
         apu_ce    <= 1'b0;
         sample_ce <= 1'b0;
      end else if (!in_run) begin
         acc       <= '0;
         samp_cnt  <= '0;
         apu_ce    <= 1'b0;
         sample_ce <= 1'b0;
      end else if (acc_sum >= DEN_W) begin
         acc    <= acc_sum - DEN_W;
         apu_ce <= 1'b1;
         if (samp_cnt == SAMP_MAX) begin
            samp_cnt  <= '0;
            sample_ce <= 1'b1;
         end else begin
            samp_cnt  <= samp_cnt + SW'(1);
            sample_ce <= 1'b0;
         end
      end else begin
         acc       <= acc_sum;
         apu_ce    <= 1'b0;
         sample_ce <= 1'b0;
      end
   end

`ifdef APU_LOCK_LOSS_CNT_EN
   // Saturating count of RUN->IDLE transitions; cleared only by rst_n.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lock_loss_cnt <= '0;
      end else if (in_run && !lock_s && (lock_loss_cnt != 8'hFF)) begin
         lock_loss_cnt <= lock_loss_cnt + 8'd1;
      end
   end
`endif

endmodule

// File: tb/tb_apu_clk_reset_gen.sv
// tb_apu_clk_reset_gen
//   Directed bench for apu_clk_reset_gen. Main instance uses SYNC_STAGES=2,
//   LOCK_HOLD=16 and the nominal 4096/4125, 768 ratios; a second instance shares
//   the inputs and covers CE_NUM == CE_DEN, SAMPLE_DIV == 1, LOCK_HOLD == 1.
//   Build with APU_LOCK_LOSS_CNT_EN to include the lock-loss counter checks.
module tb_apu_clk_reset_gen;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic pll_locked = 1'b0;

   logic apu_rst_n, apu_ce, sample_ce, lock_ok;
   logic b_apu_rst_n, b_apu_ce, b_sample_ce, b_lock_ok;
`ifdef APU_LOCK_LOSS_CNT_EN
   logic [7:0] lock_loss_cnt, b_lock_loss_cnt;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   apu_clk_reset_gen #(
      .SYNC_STAGES(2), .LOCK_HOLD(16), .CE_NUM(4096), .CE_DEN(4125), .SAMPLE_DIV(768)
   ) u_dut (
      .clk(clk), .rst_n(rst_n), .pll_locked(pll_locked),
      .apu_rst_n(apu_rst_n), .apu_ce(apu_ce), .sample_ce(sample_ce), .lock_ok(lock_ok)
`ifdef APU_LOCK_LOSS_CNT_EN
      , .lock_loss_cnt(lock_loss_cnt)
`endif
   );

   apu_clk_reset_gen #(
      .SYNC_STAGES(3), .LOCK_HOLD(1), .CE_NUM(5), .CE_DEN(5), .SAMPLE_DIV(1)
   ) u_dut_b (
      .clk(clk), .rst_n(rst_n), .pll_locked(pll_locked),
      .apu_rst_n(b_apu_rst_n), .apu_ce(b_apu_ce), .sample_ce(b_sample_ce), .lock_ok(b_lock_ok)
`ifdef APU_LOCK_LOSS_CNT_EN
      , .lock_loss_cnt(b_lock_loss_cnt)
`endif
   );

   task automatic check_eq(input string tag, input int got, input int exp);
      n_checks++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   // One clock: posedge, then land on the following negedge for sampling/driving.
   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Count clocks until apu_rst_n is seen high (bounded at 200).
   task automatic wait_release(output int n);
      n = 0;
      while (n < 200 && !apu_rst_n) begin
         tick();
         n++;
      end
   endtask

   int n, nb, b_ce_rel, lock_mis;
   int ce_cnt, sc_cnt, sc_orphan, first_ce, first_sc_idx, gap, max_gap, b_miss;

   initial begin
      #5_000_000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      // 1. Reset, then steady lock
      pll_locked = 1'b1;
      rst_n      = 1'b0;
      repeat (3) tick();
      check_eq("rst_apu_rst_n", int'(apu_rst_n), 0);
      check_eq("rst_apu_ce",    int'(apu_ce), 0);
      check_eq("rst_sample_ce", int'(sample_ce), 0);
      check_eq("rst_lock_ok",   int'(lock_ok), 0);
      check_eq("rst_b_rst_n",   int'(b_apu_rst_n), 0);
`ifdef APU_LOCK_LOSS_CNT_EN
      check_eq("rst_loss_cnt",  int'(lock_loss_cnt), 0);
`endif
      rst_n    = 1'b1;
      n        = 0;
      nb       = 0;
      b_ce_rel = -1;
      lock_mis = 0;
      while (n < 200 && !apu_rst_n) begin
         tick();
         n++;
         if (lock_ok != apu_rst_n) lock_mis++;
         if (nb == 0 && b_apu_rst_n) begin
            nb       = n;
            b_ce_rel = int'(b_apu_ce);
         end
      end
      check_eq("release_clks",    n, 20);
      check_eq("lock_ok_tracks",  lock_mis, 0);
      check_eq("lock_ok_at_rel",  int'(lock_ok), 1);
      check_eq("b_release_clks",  nb, 6);
      check_eq("b_ce_run_cycle1", b_ce_rel, 1);

      // 3. Long RUN window: 4 accumulator periods
      check_eq("run_cycle1_ce", int'(apu_ce), 0);
      ce_cnt = 0; sc_cnt = 0; sc_orphan = 0; first_ce = 0; first_sc_idx = 0;
      gap = 0; max_gap = 0; b_miss = 0;
      for (int c = 2; c <= 4125 * 4; c++) begin
         tick();
         gap++;
         if (apu_ce) begin
            ce_cnt++;
            if (first_ce == 0) first_ce = c;
            if (ce_cnt > 1 && gap > max_gap) max_gap = gap;
            gap = 0;
         end
         if (sample_ce) begin
            sc_cnt++;
            if (!apu_ce) sc_orphan++;
            if (first_sc_idx == 0) first_sc_idx = ce_cnt;
         end
         if (!b_apu_ce || (b_sample_ce != b_apu_ce)) b_miss++;
      end
      check_eq("first_ce_cycle", first_ce, 2);
      check_eq("ce_count",       ce_cnt, 16384);
      check_eq("sc_count",       sc_cnt, 21);
      check_eq("sc_orphan",      sc_orphan, 0);
      check_eq("first_sc_index", first_sc_idx, 768);
      check_eq("ce_max_gap",     max_gap, 2);
      check_eq("b_ce_every_clk", b_miss, 0);

      // 4. Lock lost in RUN, then relock
      pll_locked = 1'b0;
      repeat (3) tick();
      check_eq("drop_still_run", int'(apu_rst_n), 1);
      tick();
      check_eq("drop_apu_rst_n", int'(apu_rst_n), 0);
      check_eq("drop_apu_ce",    int'(apu_ce), 0);
      check_eq("drop_sample_ce", int'(sample_ce), 0);
      check_eq("drop_lock_ok",   int'(lock_ok), 0);
`ifdef APU_LOCK_LOSS_CNT_EN
      check_eq("loss_cnt_one",   int'(lock_loss_cnt), 1);
`endif
      pll_locked = 1'b1;
      wait_release(n);
      check_eq("relock_clks",    n, 20);
      check_eq("relock_cycle1",  int'(apu_ce), 0);
      tick();
      check_eq("relock_cycle2",  int'(apu_ce), 1);

      // 2. One-clock lock glitch while hold_cnt = 10
      pll_locked = 1'b0;
      repeat (6) tick();
      check_eq("glitch_pre_idle", int'(apu_rst_n), 0);
      pll_locked = 1'b1;
      repeat (12) tick();
      pll_locked = 1'b0;
      tick();
      pll_locked = 1'b1;
      check_eq("glitch_no_rel",  int'(apu_rst_n), 0);
      wait_release(n);
      check_eq("glitch_release", n, 20);

      // 5. Asynchronous reset mid-RUN
      repeat (5) tick();
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      check_eq("arst_apu_rst_n", int'(apu_rst_n), 0);
      check_eq("arst_apu_ce",    int'(apu_ce), 0);
      check_eq("arst_sample_ce", int'(sample_ce), 0);
      check_eq("arst_lock_ok",   int'(lock_ok), 0);
      check_eq("arst_b_ce",      int'(b_apu_ce), 0);
      @(negedge clk);
      repeat (2) tick();
      rst_n = 1'b1;
      wait_release(n);
      check_eq("arst_release",   n, 20);

`ifdef APU_LOCK_LOSS_CNT_EN
      // 6. Lock-loss counter saturation and clear
      check_eq("loss_cnt_after_rst", int'(lock_loss_cnt), 0);
      for (int k = 0; k < 300; k++) begin
         pll_locked = 1'b0;
         repeat (4) tick();
         pll_locked = 1'b1;
         wait_release(n);
         if (k == 9) check_eq("loss_cnt_ten", int'(lock_loss_cnt), 10);
      end
      check_eq("loss_cnt_sat", int'(lock_loss_cnt), 255);
      rst_n = 1'b0;
      tick();
      check_eq("loss_cnt_clear", int'(lock_loss_cnt), 0);
      rst_n = 1'b1;
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
